// File: rtl/ram_rw_ctrl.sv
// ============================================================================
// Module  : ram_rw_ctrl
// Brief   : Write-fill / cyclic-read sequencer for a single-port 8x256 RAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_rw_ctrl #(
  parameter int unsigned CNT_MAX = 25'd9_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       wr_flag,
  input  logic       rd_flag,
  output logic       wr_en,
  output logic [7:0] addr,
  output logic [7:0] wr_data,
  output logic       rd_en
);

  localparam int unsigned CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      addr    <= 8'd0;
      wr_data <= 8'd0;
      cnt     <= '0;
    end else if (wr_flag) begin
      // A write request always wins: it restarts a burst or aborts a read.
      state   <= WRITE;
      wr_en   <= 1'b1;
      rd_en   <= 1'b0;
      addr    <= 8'd0;
      wr_data <= 8'd0;
      cnt     <= '0;
    end else begin
      case (state)
        WRITE: begin
          if (addr == 8'hFF) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            addr    <= 8'd0;
            wr_data <= 8'd0;
          end else begin
            addr    <= addr + 8'd1;
            wr_data <= wr_data + 8'd1;
          end
        end
        READ: begin
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            addr <= addr + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (rd_flag) begin
            state <= READ;
            rd_en <= 1'b1;
            addr  <= 8'd0;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_rw_ctrl.sv
// ============================================================================
// Module  : tb_ram_rw_ctrl
// Brief   : Randomized self-checking bench for ram_rw_ctrl with attached RAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_rw_ctrl;

  localparam int unsigned CNT_MAX = 10;
  localparam int DWELL = CNT_MAX + 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       wr_flag = 1'b0;
  logic       rd_flag = 1'b0;
  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic       rd_en;

  ram_rw_ctrl #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_flag  (wr_flag),
    .rd_flag  (rd_flag),
    .wr_en    (wr_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en)
  );

  always #10 sys_clk = ~sys_clk;

  // Registered single-port RAM attached to the sequencer outputs.
  logic [7:0] mem [256];
  logic [7:0] q = 8'd0;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  always @(posedge sys_clk) begin
    if (!sys_rst_n) q <= 8'd0;
    else if (rd_en) q <= mem[addr];
    if (wr_en) mem[addr] <= wr_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 write, 2 read.
  int         m_mode  = 0;
  int         m_wcnt  = 0;
  int         m_rtime = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_q     = 8'd0;

  function automatic logic [7:0] m_addr();
    if (m_mode == 1) return 8'(m_wcnt);
    if (m_mode == 2) return 8'((m_rtime / DWELL) % 256);
    return 8'd0;
  endfunction

  task automatic model_edge(input logic rst_n, input logic wr, input logic rd);
    logic [7:0] a;
    a = m_addr();
    if (!rst_n) m_q = 8'd0;
    else if (m_mode == 2) m_q = m_mem[a];
    if (m_mode == 1) m_mem[a] = a;
    if (!rst_n) begin
      m_mode = 0;
    end else if (wr) begin
      m_mode = 1;
      m_wcnt = 0;
    end else if (m_mode == 1) begin
      if (m_wcnt == 255) m_mode = 0;
      else m_wcnt++;
    end else if (m_mode == 2) begin
      m_rtime++;
    end else if (rd) begin
      m_mode  = 2;
      m_rtime = 0;
    end
  endtask

  task automatic cycle(input logic rst_n, input logic wr, input logic rd);
    sys_rst_n = rst_n;
    wr_flag   = wr;
    rd_flag   = rd;
    @(posedge sys_clk);
    model_edge(rst_n, wr, rd);
    #1;
    check_eq("wr_en",   {31'd0, wr_en}, {31'd0, m_mode == 1});
    check_eq("rd_en",   {31'd0, rd_en}, {31'd0, m_mode == 2});
    check_eq("addr",    {24'd0, addr}, {24'd0, m_addr()});
    check_eq("wr_data", {24'd0, wr_data}, {24'd0, (m_mode == 1) ? m_addr() : 8'd0});
    check_eq("q",       {24'd0, q}, {24'd0, m_q});
    check_eq("excl",    {31'd0, wr_en & rd_en}, 32'd0);
  endtask

  function automatic logic rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;

    // Reset held two clocks
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    // Read of cleared RAM through a full wrap, stray rd_flags ignored
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 256 * DWELL + 20; i++) cycle(1'b1, 1'b0, rnd(3));

    // Write during read near the end of that wrap, then full burst with stray rd_flags
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 265; i++) cycle(1'b1, 1'b0, rnd(5));

    // Read back written data across a wrap
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 256 * DWELL + 30; i++) cycle(1'b1, 1'b0, rnd(2));

    // Restart read, then write while addr is 0x37 at a random dwell offset
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (!(m_mode == 2 && m_addr() == 8'h37) && guard < 5000) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check_eq("reach_0x37", {31'd0, guard < 5000}, 32'd1);
    for (int i = 0; i < int'($urandom_range(9)); i++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("addr_0x37", {24'd0, addr}, 32'h37);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
    // Reset mid-burst abandons it
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);

    // Simultaneous flags, then a read checking that the dwell counter restarted
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 260; i++) cycle(1'b1, 1'b0, rnd(5));
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);

    // Random flag/reset traffic
    for (int i = 0; i < 6000; i++) cycle(!rnd(1) , rnd(1), rnd(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
